// File: rtl/bus_transfer_scheduler_if.sv
// Purpose: requester-side and register-bank-side signals of the bus transfer scheduler.
// Latency: none, wiring only.
// Backpressure: requests are level-held until the done/err pulse; there is no other flow control.
interface bus_transfer_scheduler_if #(
    parameter int NREG = 8,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREG)
);
    logic [NREQ-1:0]     req;
    logic [NREQ*IDW-1:0] src_id;
    logic [NREQ*IDW-1:0] dst_id;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     err;
    logic [NREG-1:0]     E;
    logic [NREG-1:0]     L;
    logic                busy;

    // Requesters / control sequencer side
    modport master (
        output req, src_id, dst_id,
        input  gnt, done, err, E, L, busy
    );

    // Scheduler side
    modport slave (
        input  req, src_id, dst_id,
        output gnt, done, err, E, L, busy
    );
endinterface

// File: rtl/bus_transfer_scheduler.sv
// Purpose: round-robin arbiter that sequences one register-to-register move over the shared bus.
// Latency: req seen in IDLE -> E in +1, E+L in +2, done in +3; next grant 2 cycles after done.
// Backpressure: losers keep req high and wait; ids are latched at grant, later input changes are ignored.
module bus_transfer_scheduler #(
    parameter int NREG = 8,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREG)
) (
    input  logic                           clk,
    input  logic                           clr,
    bus_transfer_scheduler_if.slave        bus
);

    localparam int                WW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW:0]      NREG_L = (IDW + 1)'(NREG);
    localparam logic [WW-1:0]     LAST   = WW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [WW-1:0]   r_win, r_ptr, w_pick, w_cand, w_win_nxt;
    logic [IDW-1:0]  r_src, r_dst, w_src_in, w_dst_in, w_src_nxt, w_dst_nxt;
    logic            w_found, w_ids_ok;
    logic [NREQ-1:0] r_gnt, r_done, r_err, w_gnt, w_done, w_err;
    logic [NREG-1:0] r_e, r_l, w_e, w_l;
    logic            r_busy;

    // Round-robin pick: first asserted request at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(r_ptr) + i >= NREQ) begin
                w_cand = WW'(int'(r_ptr) + i - NREQ);
            end else begin
                w_cand = WW'(int'(r_ptr) + i);
            end
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Select the winner's ids and decide whether the move is legal
    always_comb begin
        w_src_in = '0;
        w_dst_in = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick == WW'(k)) begin
                w_src_in = bus.src_id[k*IDW +: IDW];
                w_dst_in = bus.dst_id[k*IDW +: IDW];
            end
        end
        w_ids_ok = ({1'b0, w_src_in} < NREG_L) && ({1'b0, w_dst_in} < NREG_L)
                   && (w_src_in != w_dst_in);
    end

    // Next state and next latched winner/ids
    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_win_nxt   = w_pick;
                    w_src_nxt   = w_src_in;
                    w_dst_nxt   = w_dst_in;
                    w_state_nxt = w_ids_ok ? S_SETUP : S_ERR;
                end
            end
            S_SETUP: w_state_nxt = S_XFER;
            S_XFER:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Decode the outputs for the state about to be entered, so they are registered
    always_comb begin
        w_gnt  = '0;
        w_done = '0;
        w_err  = '0;
        w_e    = '0;
        w_l    = '0;
        case (w_state_nxt)
            S_SETUP: begin
                w_gnt = {{(NREQ-1){1'b0}}, 1'b1} << w_win_nxt;
                w_e   = {{(NREG-1){1'b0}}, 1'b1} << w_src_nxt;
            end
            S_XFER: begin
                w_gnt = {{(NREQ-1){1'b0}}, 1'b1} << w_win_nxt;
                w_e   = {{(NREG-1){1'b0}}, 1'b1} << w_src_nxt;
                w_l   = {{(NREG-1){1'b0}}, 1'b1} << w_dst_nxt;
            end
            S_DONE: begin
                w_gnt  = {{(NREQ-1){1'b0}}, 1'b1} << w_win_nxt;
                w_done = {{(NREQ-1){1'b0}}, 1'b1} << w_win_nxt;
            end
            S_ERR: begin
                w_err = {{(NREQ-1){1'b0}}, 1'b1} << w_win_nxt;
            end
            default: ;
        endcase
    end

    // State, latched move, and round-robin pointer (advances past the winner on completion)
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_win   <= w_win_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            if (r_state == S_DONE || r_state == S_ERR) begin
                r_ptr <= (r_win == LAST) ? '0 : r_win + 1'b1;
            end
        end
    end

    // Output registers; reset drops E/L at once, abandoning any move in flight
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_gnt  <= '0;
            r_done <= '0;
            r_err  <= '0;
            r_e    <= '0;
            r_l    <= '0;
            r_busy <= 1'b0;
        end else begin
            r_gnt  <= w_gnt;
            r_done <= w_done;
            r_err  <= w_err;
            r_e    <= w_e;
            r_l    <= w_l;
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.E    = r_e;
    assign bus.L    = r_l;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_bus_transfer_scheduler.sv
// Purpose: self-checking bench for bus_transfer_scheduler against a move-timeline reference model.
// Latency: outputs compared every falling edge against the model's expectation for that cycle.
// Backpressure: bench requesters hold req until done/err, with random drops and id changes mid-move.
module tb_bus_transfer_scheduler;

    localparam int NREG = 8;
    localparam int NREQ = 4;
    // One extra id bit so out-of-range register ids can actually be presented
    localparam int IDW  = 4;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    bus_transfer_scheduler_if #(.NREG(NREG), .NREQ(NREQ), .IDW(IDW)) bus ();

    bus_transfer_scheduler #(.NREG(NREG), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bus-attached register bank driven by E/L, plus the model's view of it
    logic [7:0] bank     [NREG] = '{8'h11, 8'hAC, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] exp_bank [NREG] = '{8'h11, 8'hAC, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] bus_val;

    always_comb begin
        bus_val = '0;
        for (int j = 0; j < NREG; j++) if (bus.E[j]) bus_val = bus_val | bank[j];
    end

    always @(posedge clk) begin
        for (int j = 0; j < NREG; j++) if (bus.L[j]) bank[j] <= bus_val;
    end

    // Reference model: m_off counts cycles since the grant (0 = nothing in progress)
    int m_off = 0, m_w = 0, m_s = 0, m_d = 0, m_ptr = 0;
    bit m_ok = 1'b0;

    task automatic model_reset();
        m_off = 0;
        m_ptr = 0;
    endtask

    // Consume the inputs that the coming rising edge will sample
    task automatic model_advance();
        logic [IDW-1:0] ts, td;
        int k;
        if (!clr) begin
            model_reset();
            return;
        end
        if (m_off == 0) begin
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (m_off == 0 && bus.req[k]) begin
                    ts    = bus.src_id[k*IDW +: IDW];
                    td    = bus.dst_id[k*IDW +: IDW];
                    m_w   = k;
                    m_s   = int'(ts);
                    m_d   = int'(td);
                    m_ok  = (m_s < NREG) && (m_d < NREG) && (m_s != m_d);
                    m_off = 1;
                end
            end
        end else if (m_ok && m_off == 2) begin
            exp_bank[m_d] = exp_bank[m_s];
            m_off = 3;
        end else if ((m_ok && m_off == 3) || (!m_ok && m_off == 1)) begin
            m_ptr = (m_w + 1) % NREQ;
            m_off = 0;
        end else begin
            m_off++;
        end
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] eg, ed, ee;
        logic [NREG-1:0] eE, eL;
        logic [63:0]     pa, pb;
        eg = '0; ed = '0; ee = '0; eE = '0; eL = '0;
        if (m_off != 0) begin
            if (m_ok) begin
                eg[m_w] = 1'b1;
                if (m_off <= 2) eE[m_s] = 1'b1;
                if (m_off == 2) eL[m_d] = 1'b1;
                if (m_off == 3) ed[m_w] = 1'b1;
            end else begin
                ee[m_w] = 1'b1;
            end
        end
        chk("gnt",  bus.gnt,  eg);
        chk("done", bus.done, ed);
        chk("err",  bus.err,  ee);
        chk("E",    bus.E,    eE);
        chk("L",    bus.L,    eL);
        chk("busy", bus.busy, (m_off != 0));
        chk("inv_E_onehot0",   $onehot0(bus.E),   1);
        chk("inv_L_onehot0",   $onehot0(bus.L),   1);
        chk("inv_gnt_onehot0", $onehot0(bus.gnt), 1);
        chk("inv_E_and_L",     bus.E & bus.L,     0);
        chk("inv_L_without_E", (bus.L != 0) && (bus.E == 0), 0);
        pa = '0; pb = '0;
        for (int j = 0; j < NREG; j++) begin
            pa[j*8 +: 8] = bank[j];
            pb[j*8 +: 8] = exp_bank[j];
        end
        chk("bank", pa, pb);
    endtask

    // One clock: inputs already driven at the falling edge, compare at the next falling edge
    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_req(input int k, input bit on, input int s, input int d);
        bus.req[k]                = on;
        bus.src_id[k*IDW +: IDW]  = IDW'(s);
        bus.dst_id[k*IDW +: IDW]  = IDW'(d);
    endtask

    task automatic do_reset();
        clr     = 1'b0;
        bus.req = '0;
        model_reset();
        tick();
        clr = 1'b1;
    endtask

    int         q_who[$];
    int         q_when[$];
    bit [NREQ-1:0] pend;
    logic [7:0] v4;

    initial begin
        bus.req    = '0;
        bus.src_id = '0;
        bus.dst_id = '0;

        // Reset state
        @(negedge clk);
        chk("rst_gnt",  bus.gnt,  0);
        chk("rst_done", bus.done, 0);
        chk("rst_err",  bus.err,  0);
        chk("rst_E",    bus.E,    0);
        chk("rst_L",    bus.L,    0);
        chk("rst_busy", bus.busy, 0);
        clr = 1'b1;

        // Basic move: register 1 -> register 0
        set_req(0, 1, 1, 0);
        tick();
        chk("t1_c1_E", bus.E, 8'h02);
        chk("t1_c1_L", bus.L, 8'h00);
        tick();
        chk("t1_c2_E", bus.E, 8'h02);
        chk("t1_c2_L", bus.L, 8'h01);
        tick();
        chk("t1_c3_done", bus.done, 4'b0001);
        chk("t1_c3_EL",   bus.E | bus.L, 0);
        chk("t1_reg0",    bank[0], 8'hAC);
        set_req(0, 0, 1, 0);
        tick();

        // All four requesting: round-robin order, done every 4 cycles
        do_reset();
        for (int k = 0; k < NREQ; k++) set_req(k, 1, k, k + 4);
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int k = 0; k < NREQ; k++) begin
                if (bus.done[k]) begin
                    q_who.push_back(k);
                    q_when.push_back(c);
                end
            end
        end
        chk("t2_ndone", q_who.size() >= 5, 1);
        for (int i = 0; i < 5 && i < q_who.size(); i++) begin
            chk("t2_order", q_who[i], i % NREQ);
            if (i > 0) chk("t2_spacing", q_when[i] - q_when[i-1], 4);
        end
        do_reset();

        // Illegal moves: src==dst, then out-of-range src; pointer moves past requester 2
        set_req(2, 1, 3, 3);
        tick();
        chk("t3_err_same", bus.err, 4'b0100);
        chk("t3_E_same",   bus.E,   0);
        set_req(2, 0, 3, 3);
        tick();
        set_req(2, 1, 9, 0);
        tick();
        chk("t3_err_range", bus.err, 4'b0100);
        chk("t3_L_range",   bus.L,   0);
        for (int k = 0; k < NREQ; k++) set_req(k, 1, k, k + 4);
        tick();
        tick();
        chk("t3_ptr_next", bus.gnt, 4'b1000);
        do_reset();

        // Asynchronous reset in the middle of XFER
        set_req(1, 1, 2, 5);
        tick();
        tick();
        chk("t4_in_xfer_L", bus.L, 8'h20);
        #2 clr = 1'b0;
        #1;
        chk("t4_async_E",    bus.E,    0);
        chk("t4_async_L",    bus.L,    0);
        chk("t4_async_gnt",  bus.gnt,  0);
        chk("t4_async_busy", bus.busy, 0);
        model_reset();
        tick();
        clr = 1'b1;
        tick();
        chk("t4_restart_E",   bus.E,   8'h04);
        chk("t4_restart_gnt", bus.gnt, 4'b0010);
        tick();
        tick();
        chk("t4_done", bus.done, 4'b0010);
        set_req(1, 0, 2, 5);
        tick();

        // req dropped in SETUP and src changed in XFER: latched ids still used
        v4 = bank[4];
        set_req(1, 1, 4, 6);
        tick();
        bus.req[1] = 1'b0;
        tick();
        bus.src_id[1*IDW +: IDW] = IDW'(7);
        tick();
        chk("t5_done", bus.done, 4'b0010);
        chk("t5_dst",  bank[6], v4);
        tick();

        // Random traffic
        do_reset();
        pend = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (pend[k] && (bus.done[k] || bus.err[k])) begin
                    pend[k]    = 1'b0;
                    bus.req[k] = 1'b0;
                end else if (!pend[k] && !bus.gnt[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1'b1;
                    set_req(k, 1, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
                end else if (bus.gnt[k] && $urandom_range(0, 49) == 0) begin
                    set_req(k, bit'($urandom_range(0, 1)),
                            int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
                    pend[k] = bus.req[k];
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
